display_io_hub: RTL and testbench

- Parametrised board I/O front end for the processor top level.
- Debounces NUM_BUTTONS raw active-low push buttons and produces level, press-pulse and release-pulse outputs.
- Selects one of NUM_CHANNELS hex-display sources, with optional freeze and timed auto-scan, and drives NUM_DIGITS registered active-low 7-segment digits with per-digit blanking.
- Replaces the separate per-button debouncers and the single-source hex latch/decoder path.

---
 rtl/display_io_hub.sv | 163 ++++++++++++++++
 tb/tb_display_io_hub.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_io_hub.sv
// Board I/O front end: debounced push buttons plus a multi-source, freezable,
// auto-scanning 7-segment hex display with per-digit blanking.
module display_io_hub #(
  parameter int unsigned NUM_BUTTONS  = 4,
  parameter int unsigned DB_CYCLES    = 16,
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SCAN_CYCLES  = 27000000,
  localparam int unsigned DW  = 4 * NUM_DIGITS,
  localparam int unsigned CSW = $clog2(NUM_CHANNELS)
) (
  input  logic                         clk_27,
  input  logic                         Reset,
  input  logic [NUM_BUTTONS-1:0]       pushBut_raw,
  output logic [NUM_BUTTONS-1:0]       pb_state,
  output logic [NUM_BUTTONS-1:0]       pb_press,
  output logic [NUM_BUTTONS-1:0]       pb_release,
  input  logic [NUM_CHANNELS*DW-1:0]   chan_data,
  input  logic [CSW-1:0]               chan_sel,
  input  logic                         chan_load,
  input  logic                         auto_scan,
  input  logic                         freeze,
  input  logic [NUM_DIGITS-1:0]        digit_blank,
  output logic [7*NUM_DIGITS-1:0]      hex_out,
  output logic [CSW-1:0]               active_chan,
  output logic                         frozen
);

  localparam int unsigned DBW  = $clog2(DB_CYCLES);
  localparam int unsigned SW   = $clog2(SCAN_CYCLES);
  localparam int unsigned CSW1 = CSW + 1;
  localparam int unsigned HW   = 7 * NUM_DIGITS;

  // Active-low segment pattern, bit0 = a .. bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [NUM_BUTTONS-1:0]           sync1;
  logic [NUM_BUTTONS-1:0]           sync2;
  logic [NUM_BUTTONS-1:0]           pressed_c;
  logic [NUM_BUTTONS-1:0][DBW-1:0]  db_cnt;
  logic [NUM_BUTTONS-1:0][DBW-1:0]  db_cnt_nxt;
  logic [NUM_BUTTONS-1:0]           pb_state_nxt;
  logic [NUM_BUTTONS-1:0]           pb_press_nxt;
  logic [NUM_BUTTONS-1:0]           pb_release_nxt;

  logic [SW-1:0]                    scan_cnt;
  logic [SW-1:0]                    scan_nxt;
  logic [CSW-1:0]                   chan_nxt;
  logic                             sel_ok_c;

  logic [DW-1:0]                    chan_mux_c;
  logic [DW-1:0]                    disp_reg;
  logic [DW-1:0]                    disp_nxt;
  logic [HW-1:0]                    hex_nxt;

  assign pressed_c = ~sync2;
  assign sel_ok_c  = (CSW1'(chan_sel) < CSW1'(NUM_CHANNELS));

  // Debounce: a button flips only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_cnt_nxt     = db_cnt;
    pb_state_nxt   = pb_state;
    pb_press_nxt   = '0;
    pb_release_nxt = '0;
    for (int unsigned b = 0; b < NUM_BUTTONS; b++) begin
      if (pressed_c[b] == pb_state[b]) begin
        db_cnt_nxt[b] = '0;
      end else if (db_cnt[b] == DBW'(DB_CYCLES - 1)) begin
        db_cnt_nxt[b]     = '0;
        pb_state_nxt[b]   = pressed_c[b];
        pb_press_nxt[b]   = pressed_c[b];
        pb_release_nxt[b] = ~pressed_c[b];
      end else begin
        db_cnt_nxt[b] = db_cnt[b] + DBW'(1);
      end
    end
  end

  // Channel selection: explicit load beats auto-scan; freeze pauses the scan timer.
  always_comb begin
    chan_nxt = active_chan;
    scan_nxt = scan_cnt;
    if (chan_load) begin
      if (sel_ok_c) begin
        chan_nxt = chan_sel;
        scan_nxt = '0;
      end
    end else if (auto_scan && !freeze) begin
      if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
        chan_nxt = (active_chan == CSW'(NUM_CHANNELS - 1)) ? '0 : active_chan + CSW'(1);
        scan_nxt = '0;
      end else begin
        scan_nxt = scan_cnt + SW'(1);
      end
    end
  end

  always_comb begin
    chan_mux_c = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      if (active_chan == CSW'(k)) chan_mux_c = chan_data[k*DW +: DW];
    end
  end

  // Display latch and segment decode; blanked digits are forced fully dark.
  always_comb begin
    disp_nxt = freeze ? disp_reg : chan_mux_c;
    hex_nxt  = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      hex_nxt[7*i +: 7] = digit_blank[i] ? 7'h7F : seg7(disp_reg[4*i +: 4]);
    end
  end

  always_ff @(posedge clk_27) begin
    if (Reset) begin
      sync1       <= '1;
      sync2       <= '1;
      db_cnt      <= '0;
      pb_state    <= '0;
      pb_press    <= '0;
      pb_release  <= '0;
      active_chan <= '0;
      scan_cnt    <= '0;
      disp_reg    <= '0;
      frozen      <= 1'b0;
      hex_out     <= '1;
    end else begin
      sync1       <= pushBut_raw;
      sync2       <= sync1;
      db_cnt      <= db_cnt_nxt;
      pb_state    <= pb_state_nxt;
      pb_press    <= pb_press_nxt;
      pb_release  <= pb_release_nxt;
      active_chan <= chan_nxt;
      scan_cnt    <= scan_nxt;
      disp_reg    <= disp_nxt;
      frozen      <= freeze;
      hex_out     <= hex_nxt;
    end
  end

endmodule

// File: tb/tb_display_io_hub.sv
// Scoreboard bench for display_io_hub: a 4-channel and a 3-channel instance
// are compared every cycle against a behavioural model, plus directed spot checks.
module tb_display_io_hub;

  localparam int NB  = 4;
  localparam int DB  = 4;
  localparam int ND  = 8;
  localparam int SC  = 8;
  localparam int NC0 = 4;
  localparam int NC1 = 3;

  localparam int K_HEX   = 0;
  localparam int K_PRESS = 1;
  localparam int K_STATE = 2;
  localparam int K_REL   = 3;
  localparam int K_AC    = 4;

  logic          clk_27 = 1'b0;
  logic          Reset;
  logic [NB-1:0] raw;
  logic [127:0]  cd;
  logic [1:0]    sel;
  logic          ld, as, fz;
  logic [ND-1:0] blank;

  logic [NB-1:0] st0, pr0, rl0, st1, pr1, rl1;
  logic [55:0]   hex0, hex1;
  logic [1:0]    ac0, ac1;
  logic          frz0, frz1;

  always #5 clk_27 = ~clk_27;

  display_io_hub #(.NUM_BUTTONS(NB), .DB_CYCLES(DB), .NUM_DIGITS(ND),
                   .NUM_CHANNELS(NC0), .SCAN_CYCLES(SC)) dut0 (
    .clk_27(clk_27), .Reset(Reset), .pushBut_raw(raw),
    .pb_state(st0), .pb_press(pr0), .pb_release(rl0),
    .chan_data(cd), .chan_sel(sel), .chan_load(ld), .auto_scan(as),
    .freeze(fz), .digit_blank(blank), .hex_out(hex0),
    .active_chan(ac0), .frozen(frz0));

  display_io_hub #(.NUM_BUTTONS(NB), .DB_CYCLES(DB), .NUM_DIGITS(ND),
                   .NUM_CHANNELS(NC1), .SCAN_CYCLES(SC)) dut1 (
    .clk_27(clk_27), .Reset(Reset), .pushBut_raw(raw),
    .pb_state(st1), .pb_press(pr1), .pb_release(rl1),
    .chan_data(cd[95:0]), .chan_sel(sel), .chan_load(ld), .auto_scan(as),
    .freeze(fz), .digit_blank(blank), .hex_out(hex1),
    .active_chan(ac1), .frozen(frz1));

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: debounce kept as a window of the last DB synchronised samples.
  typedef struct packed {
    logic [NB-1:0]         s1;
    logic [NB-1:0]         s2;
    logic [NB-1:0][DB-1:0] hist;
    logic [NB-1:0]         st;
    logic [NB-1:0]         pr;
    logic [NB-1:0]         rl;
    logic [1:0]            ac;
    int unsigned           scnt;
    logic [31:0]           disp;
    logic                  frz;
    logic [55:0]           hex;
  } mstate_t;

  typedef struct packed {
    logic [NB-1:0] st;
    logic [NB-1:0] pr;
    logic [NB-1:0] rl;
    logic [55:0]   hex;
    logic [1:0]    ac;
    logic          frz;
  } exp_t;

  typedef struct packed {
    int          cyc;
    int          kind;
    logic [63:0] val;
  } dir_t;

  mstate_t m0, m1;
  exp_t    q0[$];
  exp_t    q1[$];
  dir_t    dq[$];
  int      cyc = 0;
  int      checks = 0;
  int      failures = 0;
  bit      done = 1'b0;

  function automatic mstate_t step(input mstate_t m, input logic rst, input logic [NB-1:0] rw,
                                   input logic [127:0] data, input logic [1:0] s,
                                   input logic l, input logic a, input logic f,
                                   input logic [ND-1:0] bl, input int nch);
    mstate_t n;
    logic    p;
    int      nxt_ch;
    n = m;
    if (rst) begin
      n     = '0;
      n.s1  = '1;
      n.s2  = '1;
      n.hex = '1;
      return n;
    end
    n.pr = '0;
    n.rl = '0;
    for (int b = 0; b < NB; b++) begin
      p = ~m.s2[b];
      n.hist[b] = {m.hist[b][DB-2:0], p};
      if (n.hist[b] == {DB{~m.st[b]}}) begin
        n.st[b] = ~m.st[b];
        n.pr[b] = p;
        n.rl[b] = ~p;
      end
    end
    n.s2 = m.s1;
    n.s1 = rw;
    for (int i = 0; i < ND; i++) n.hex[7*i +: 7] = bl[i] ? 7'h7F : seg_tab[m.disp[4*i +: 4]];
    if (!f) n.disp = data[32*m.ac +: 32];
    n.frz = f;
    if (l) begin
      if (int'(s) < nch) begin
        n.ac   = s;
        n.scnt = 0;
      end
    end else if (a && !f) begin
      if (m.scnt == SC - 1) begin
        nxt_ch = (int'(m.ac) + 1) % nch;
        n.ac   = 2'(nxt_ch);
        n.scnt = 0;
      end else begin
        n.scnt = m.scnt + 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t to_exp(input mstate_t m);
    return '{st: m.st, pr: m.pr, rl: m.rl, hex: m.hex, ac: m.ac, frz: m.frz};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic add_dir(input int c, input int k, input logic [63:0] v);
    dq.push_back('{cyc: c, kind: k, val: v});
  endtask

  // Reference model: advances on every edge and queues the expected outputs.
  initial begin
    forever begin
      @(posedge clk_27);
      cyc++;
      m0 = step(m0, Reset, raw, cd, sel, ld, as, fz, blank, NC0);
      m1 = step(m1, Reset, raw, {32'h0, cd[95:0]}, sel, ld, as, fz, blank, NC1);
      q0.push_back(to_exp(m0));
      q1.push_back(to_exp(m1));
    end
  end

  // Monitor: pops expectations and compares mid-cycle.
  initial begin
    exp_t e;
    dir_t d;
    forever begin
      @(negedge clk_27);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d0_pb_state", 64'(st0), 64'(e.st));
        chk("d0_pb_press", 64'(pr0), 64'(e.pr));
        chk("d0_pb_release", 64'(rl0), 64'(e.rl));
        chk("d0_hex_out", 64'(hex0), 64'(e.hex));
        chk("d0_active_chan", 64'(ac0), 64'(e.ac));
        chk("d0_frozen", 64'(frz0), 64'(e.frz));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1_pb_state", 64'(st1), 64'(e.st));
        chk("d1_pb_press", 64'(pr1), 64'(e.pr));
        chk("d1_pb_release", 64'(rl1), 64'(e.rl));
        chk("d1_hex_out", 64'(hex1), 64'(e.hex));
        chk("d1_active_chan", 64'(ac1), 64'(e.ac));
        chk("d1_frozen", 64'(frz1), 64'(e.frz));
      end
      for (int i = dq.size() - 1; i >= 0; i--) begin
        d = dq[i];
        if (d.cyc == cyc) begin
          case (d.kind)
            K_HEX:   chk("dir_hex_out", 64'(hex0), d.val);
            K_PRESS: chk("dir_pb_press", 64'(pr0), d.val);
            K_STATE: chk("dir_pb_state", 64'(st0), d.val);
            K_REL:   chk("dir_pb_release", 64'(rl0), d.val);
            default: chk("dir_active_chan", 64'(ac0), d.val);
          endcase
          dq.delete(i);
        end else if (d.cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL dir_missed kind=%0d cyc=%0d actual=skipped required=checked", d.kind, d.cyc);
          dq.delete(i);
        end
      end
      if (done) begin
        checks++;
        if (dq.size() != 0) begin
          failures++;
          $display("FAIL dir_pending actual=%0d required=0", dq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    int c;
    int k;
    Reset = 1'b1;
    raw   = '1;
    cd    = '0;
    sel   = '0;
    ld    = 1'b0;
    as    = 1'b0;
    fz    = 1'b0;
    blank = '0;

    add_dir(2, K_HEX, 64'({56{1'b1}}));
    add_dir(2, K_AC, 64'd0);
    add_dir(3, K_HEX, 64'({8{7'h40}}));
    add_dir(3, K_PRESS, 64'd0);
    add_dir(3, K_STATE, 64'd0);
    repeat (2) @(negedge clk_27);
    Reset = 1'b0;
    repeat (3) @(negedge clk_27);

    // Clean press and release of button 2.
    c = cyc;
    raw[2] = 1'b0;
    add_dir(c + 5, K_PRESS, 64'd0);
    add_dir(c + 6, K_PRESS, 64'h4);
    add_dir(c + 6, K_STATE, 64'h4);
    add_dir(c + 7, K_PRESS, 64'd0);
    repeat (12) @(negedge clk_27);
    c = cyc;
    raw[2] = 1'b1;
    add_dir(c + 5, K_REL, 64'd0);
    add_dir(c + 6, K_REL, 64'h4);
    add_dir(c + 6, K_STATE, 64'd0);
    add_dir(c + 7, K_REL, 64'd0);
    repeat (12) @(negedge clk_27);

    // Bouncing input: never stable long enough to register.
    for (int i = 0; i < 10; i++) begin
      raw[2] = ~raw[2];
      c = cyc;
      add_dir(c + 1, K_STATE, 64'd0);
      repeat (2) @(negedge clk_27);
    end
    repeat (8) @(negedge clk_27);

    // Load channel 2 and see its digits three cycles later.
    cd[64 +: 32] = 32'h1234ABCD;
    sel = 2'd2;
    ld  = 1'b1;
    c = cyc;
    add_dir(c + 1, K_AC, 64'd2);
    add_dir(c + 3, K_HEX, 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}));
    @(negedge clk_27);
    ld = 1'b0;
    repeat (5) @(negedge clk_27);

    // Auto-scan from channel 3, wrapping to 0 then 1, then frozen.
    sel = 2'd3;
    ld  = 1'b1;
    @(negedge clk_27);
    ld = 1'b0;
    as = 1'b1;
    c = cyc;
    add_dir(c + 7, K_AC, 64'd3);
    add_dir(c + 8, K_AC, 64'd0);
    add_dir(c + 16, K_AC, 64'd1);
    repeat (17) @(negedge clk_27);
    fz = 1'b1;
    c = cyc;
    add_dir(c + 11, K_AC, 64'd1);
    repeat (12) @(negedge clk_27);
    sel = 2'd3;
    ld  = 1'b1;
    @(negedge clk_27);
    ld = 1'b0;
    as = 1'b0;
    repeat (4) @(negedge clk_27);

    // Frozen display ignores new data until freeze drops; then blanking.
    sel = 2'd0;
    ld  = 1'b1;
    @(negedge clk_27);
    ld = 1'b0;
    cd[0 +: 32] = 32'hFFFFFFFF;
    repeat (6) @(negedge clk_27);
    fz = 1'b0;
    c = cyc;
    add_dir(c + 2, K_HEX, 64'({8{7'h0E}}));
    repeat (2) @(negedge clk_27);
    blank = 8'h0F;
    c = cyc;
    add_dir(c + 1, K_HEX, 64'({{4{7'h0E}}, {4{7'h7F}}}));
    repeat (3) @(negedge clk_27);
    blank = '0;

    // Reset in the middle of a scan step and a button count.
    as  = 1'b1;
    sel = 2'd1;
    ld  = 1'b1;
    @(negedge clk_27);
    ld = 1'b0;
    repeat (3) @(negedge clk_27);
    raw[0] = 1'b0;
    repeat (2) @(negedge clk_27);
    Reset = 1'b1;
    c = cyc;
    add_dir(c + 1, K_PRESS, 64'd0);
    add_dir(c + 1, K_STATE, 64'd0);
    add_dir(c + 1, K_HEX, 64'({56{1'b1}}));
    add_dir(c + 1, K_AC, 64'd0);
    @(negedge clk_27);
    Reset = 1'b0;
    repeat (10) @(negedge clk_27);
    raw = '1;
    as  = 1'b0;
    repeat (10) @(negedge clk_27);

    // Randomized traffic.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        k = int'($urandom_range(0, NB - 1));
        raw[k] = ~raw[k];
      end
      if ($urandom_range(0, 12) == 0) begin
        k = int'($urandom_range(0, 3));
        cd[32*k +: 32] = $urandom();
      end
      ld  = ($urandom_range(0, 19) == 0);
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) as = ~as;
      if ($urandom_range(0, 50) == 0) fz = ~fz;
      if ($urandom_range(0, 30) == 0) blank = 8'($urandom());
      Reset = ($urandom_range(0, 249) == 0);
      @(negedge clk_27);
    end
    Reset = 1'b0;
    ld    = 1'b0;
    repeat (4) @(negedge clk_27);
    done = 1'b1;
  end

endmodule
